// File: rtl/zl_ts_packet_mux_if.sv
// ---------------------------------------------------------------------------
// zl_ts_packet_mux_if
// Byte-stream bundle for the TS packet multiplexer: two byte-wide req/ack
// sources and one req/ack output stream with a start-of-packet marker.
//
// Signals:
//   src0_req / src0_ack / src0_data[7:0]   source 0 byte handshake
//   src1_req / src1_ack / src1_data[7:0]   source 1 byte handshake
//   data_out_req / data_out_ack / data_out[7:0] / data_out_sop
//                                          multiplexed output stream
//
// Modports:
//   master  the environment: drives source bytes and the downstream ack
//   slave   the multiplexer: drives source acks and the output stream
// ---------------------------------------------------------------------------
interface zl_ts_packet_mux_if;
  logic       src0_req;
  logic       src0_ack;
  logic [7:0] src0_data;
  logic       src1_req;
  logic       src1_ack;
  logic [7:0] src1_data;
  logic       data_out_req;
  logic       data_out_ack;
  logic [7:0] data_out;
  logic       data_out_sop;

  modport master (
    output src0_req, src0_data, src1_req, src1_data, data_out_ack,
    input  src0_ack, src1_ack, data_out_req, data_out, data_out_sop
  );

  modport slave (
    input  src0_req, src0_data, src1_req, src1_data, data_out_ack,
    output src0_ack, src1_ack, data_out_req, data_out, data_out_sop
  );
endinterface

// File: rtl/zl_ts_packet_mux.sv
// ---------------------------------------------------------------------------
// zl_ts_packet_mux
// Schedules whole MPEG-TS packets from two byte-wide sources onto a single
// req/ack output stream. While idle, each source is hunted for alignment:
// non-sync bytes are acked and discarded, a sync byte makes the source a
// candidate. Ties between candidates are broken round-robin. Once granted,
// a packet is forwarded in full with no further sync checking.
//
// Optional feature (compile-time macro ZL_TS_NULL_INSERT_EN):
//   when defined, idle output slots with downstream ready are filled with
//   complete null packets (PID 0x1FFF) so the output never starves.
//
// Parameters:
//   Packet_len  bytes per TS packet (byte counter is 8 bits wide)
//   Sync_byte   TS sync byte
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    zl_ts_packet_mux_if.slave (source handshakes + output stream)
// ---------------------------------------------------------------------------
module zl_ts_packet_mux #(
  parameter int         Packet_len = 188,
  parameter logic [7:0] Sync_byte  = 8'h47
) (
  input  logic               clk,
  input  logic               rst_n,
  zl_ts_packet_mux_if.slave  bus
);

  localparam logic [7:0] LastIdx = 8'(Packet_len - 1);

  typedef enum logic [1:0] {
    S_idle = 2'd0,
    S_src  = 2'd1,
    S_null = 2'd2
  } state_t;

  state_t     state_reg;
  logic       grant_reg;
  logic       rr_ptr_reg;
  logic [7:0] byte_count_reg;

  // Sources gathered into arrays so per-source logic can be generated.
  logic [1:0] src_req;
  logic [7:0] src_data [2];
  logic [1:0] cand;
  logic [1:0] hunt_ack;

  assign src_req     = {bus.src1_req, bus.src0_req};
  assign src_data[0] = bus.src0_data;
  assign src_data[1] = bus.src1_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // A source presenting a sync byte is packet-aligned; anything else
      // offered while idle is swallowed to advance the alignment hunt.
      assign cand[gi]     = src_req[gi] && (src_data[gi] == Sync_byte);
      assign hunt_ack[gi] = src_req[gi] && (src_data[gi] != Sync_byte);
    end
  endgenerate

  logic       sel_req;
  logic [7:0] sel_data;
  logic       src_xfer;
  logic       last_byte;

  assign sel_req   = src_req[grant_reg];
  assign sel_data  = src_data[grant_reg];
  assign src_xfer  = (state_reg == S_src) && sel_req && bus.data_out_ack;
  assign last_byte = (byte_count_reg == LastIdx);

`ifdef ZL_TS_NULL_INSERT_EN
  // Null packet header: sync, PID 0x1FFF, payload-only with CC=0,
  // then stuffing bytes.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = Sync_byte;
      8'd1:    b = 8'h1F;
      8'd2:    b = 8'hFF;
      8'd3:    b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction
`endif

  // Output path is combinational from the source so a byte can be passed
  // through in the same cycle it is offered.
  logic [1:0] src_ack;
  logic       out_req;
  logic [7:0] out_data;
  logic       out_sop;

  always_comb begin
    src_ack  = 2'b00;
    out_req  = 1'b0;
    out_data = 8'h00;
    out_sop  = 1'b0;
    case (state_reg)
      S_idle: begin
        src_ack = hunt_ack;
      end
      S_src: begin
        out_req            = sel_req;
        out_data           = sel_data;
        out_sop            = (byte_count_reg == 8'd0) && sel_req;
        src_ack[grant_reg] = sel_req && bus.data_out_ack;
      end
`ifdef ZL_TS_NULL_INSERT_EN
      S_null: begin
        out_req  = 1'b1;
        out_data = null_byte(byte_count_reg);
        out_sop  = (byte_count_reg == 8'd0);
      end
`endif
      default: begin
        src_ack = 2'b00;
      end
    endcase
  end

  assign bus.src0_ack     = src_ack[0];
  assign bus.src1_ack     = src_ack[1];
  assign bus.data_out_req = out_req;
  assign bus.data_out     = out_data;
  assign bus.data_out_sop = out_sop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_idle;
      grant_reg      <= 1'b0;
      rr_ptr_reg     <= 1'b0;
      byte_count_reg <= 8'd0;
    end else begin
      case (state_reg)
        S_idle: begin
          byte_count_reg <= 8'd0;
          if (|cand) begin
            state_reg <= S_src;
            // Tie goes to the round-robin pointer, otherwise the lone
            // candidate (cand[1] is 1 exactly when only source 1 qualifies).
            grant_reg <= (&cand) ? rr_ptr_reg : cand[1];
          end
`ifdef ZL_TS_NULL_INSERT_EN
          else if (bus.data_out_ack) begin
            state_reg <= S_null;
          end
`endif
        end
        S_src: begin
          if (src_xfer) begin
            if (last_byte) begin
              state_reg      <= S_idle;
              rr_ptr_reg     <= ~grant_reg;
              byte_count_reg <= 8'd0;
            end else begin
              byte_count_reg <= byte_count_reg + 8'd1;
            end
          end
        end
`ifdef ZL_TS_NULL_INSERT_EN
        S_null: begin
          // A started null packet always runs to completion.
          if (bus.data_out_ack) begin
            if (last_byte) begin
              state_reg      <= S_idle;
              byte_count_reg <= 8'd0;
            end else begin
              byte_count_reg <= byte_count_reg + 8'd1;
            end
          end
        end
`endif
        default: begin
          state_reg      <= S_idle;
          byte_count_reg <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zl_ts_packet_mux.sv
// ---------------------------------------------------------------------------
// tb_zl_ts_packet_mux
// Self-checking bench for zl_ts_packet_mux. Sources are byte queues offered
// with random req, the downstream ack is random. A packet-level reference
// model (who owns the output, how far into the packet, who has priority)
// predicts every output and ack on every cycle; directed scenarios add
// literal expectations on the captured output stream.
// Honours ZL_TS_NULL_INSERT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_zl_ts_packet_mux;

`ifdef ZL_TS_NULL_INSERT_EN
  localparam bit NULL_EN = 1'b1;
`else
  localparam bit NULL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  zl_ts_packet_mux_if bus ();

  zl_ts_packet_mux #(
    .Packet_len (188),
    .Sync_byte  (8'h47)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Source byte streams and stimulus knobs.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int unsigned pct0 = 0, pct1 = 0, ack_pct = 100;
  logic        pop0 = 1'b0, pop1 = 1'b0;

  // Captured output stream.
  logic [7:0] out_q[$];
  logic       sop_q[$];
  int         sop_cyc[$];
  int         ncyc = 0;

  // Reference model: owner -1 = nobody, 0/1 = source packet, 2 = null packet.
  bit   model_on = 1'b0;
  int   owner = -1;
  int   pos = 0;
  int   prio = 0;

  function automatic logic [7:0] null_ref(input int p);
    if (p == 0) return 8'h47;
    if (p == 1) return 8'h1F;
    if (p == 3) return 8'h10;
    return 8'hFF;
  endfunction

  logic       r0, r1, oa, own_r, e_req, e_sop, e_ack0, e_ack1;
  logic [7:0] d0, d1, own_d, e_data;

  always @(negedge clk) begin
    ncyc++;
    r0 = bus.src0_req;  d0 = bus.src0_data;
    r1 = bus.src1_req;  d1 = bus.src1_data;
    oa = bus.data_out_ack;
    own_r = (owner == 1) ? r1 : r0;
    own_d = (owner == 1) ? d1 : d0;
    if (model_on) begin
      e_req = 1'b0; e_data = 8'h00; e_sop = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
      if (owner < 0) begin
        e_ack0 = r0 && (d0 != 8'h47);
        e_ack1 = r1 && (d1 != 8'h47);
      end else if (owner == 2) begin
        e_req  = 1'b1;
        e_data = null_ref(pos);
        e_sop  = (pos == 0);
      end else begin
        e_req  = own_r;
        e_data = own_d;
        e_sop  = (pos == 0) && own_r;
        if (owner == 0) e_ack0 = own_r && oa;
        else            e_ack1 = own_r && oa;
      end
      chk("data_out_req", 32'(bus.data_out_req), 32'(e_req));
      chk("data_out",     32'(bus.data_out),     32'(e_data));
      chk("data_out_sop", 32'(bus.data_out_sop), 32'(e_sop));
      chk("src0_ack",     32'(bus.src0_ack),     32'(e_ack0));
      chk("src1_ack",     32'(bus.src1_ack),     32'(e_ack1));
      if (bus.data_out_req && oa) begin
        out_q.push_back(bus.data_out);
        sop_q.push_back(bus.data_out_sop);
        if (bus.data_out_sop) sop_cyc.push_back(ncyc);
      end
    end
    pop0 = r0 && bus.src0_ack;
    pop1 = r1 && bus.src1_ack;
    // Advance the model to the state after the coming rising edge.
    if (!rst_n) begin
      model_on = 1'b1;
      owner = -1; pos = 0; prio = 0;
    end else if (model_on) begin
      if (owner < 0) begin
        pos = 0;
        if (r0 && d0 == 8'h47 && r1 && d1 == 8'h47) owner = prio;
        else if (r0 && d0 == 8'h47)                 owner = 0;
        else if (r1 && d1 == 8'h47)                 owner = 1;
        else if (NULL_EN && oa)                     owner = 2;
      end else if (owner == 2) begin
        if (oa) begin
          pos++;
          if (pos == 188) begin owner = -1; pos = 0; end
        end
      end else if (own_r && oa) begin
        pos++;
        if (pos == 188) begin prio = 1 - owner; owner = -1; pos = 0; end
      end
    end
  end

  // One clock of stimulus: retire consumed bytes, then offer the next ones.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop0 && q0.size() > 0) void'(q0.pop_front());
    if (pop1 && q1.size() > 0) void'(q1.pop_front());
    bus.src0_req     = (q0.size() > 0) && ($urandom_range(99) < pct0);
    bus.src0_data    = (q0.size() > 0) ? q0[0] : 8'h00;
    bus.src1_req     = (q1.size() > 0) && ($urandom_range(99) < pct1);
    bus.src1_data    = (q1.size() > 0) ? q1[0] : 8'h00;
    bus.data_out_ack = ($urandom_range(99) < ack_pct);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pct0 = 0; pct1 = 0; ack_pct = 100;
    q0.delete(); q1.delete();
    step(); step(); step();
    out_q.delete(); sop_q.delete(); sop_cyc.delete();
  endtask

  // Present the loaded queues while still in reset, then release.
  task automatic release_rst();
    step();
    rst_n = 1'b1;
  endtask

  // kind 0: constant fill, 1: random, 2: random without 0x47, 3: 00..BA
  task automatic push_pkt(input int s, input int kind, input logic [7:0] fill);
    logic [7:0] b;
    for (int i = 0; i < 188; i++) begin
      if (i == 0) b = 8'h47;
      else begin
        case (kind)
          0: b = fill;
          1: b = 8'($urandom_range(255));
          2: begin b = 8'($urandom_range(255)); if (b == 8'h47) b = 8'h48; end
          default: b = 8'(i - 1);
        endcase
      end
      if (s == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic run_until(input string nm, input int n, input int limit);
    for (int k = 0; k < limit && out_q.size() < n; k++) step();
    chk(nm, 32'(out_q.size() >= n), 32'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  logic [7:0] ref_q[$];
  int         off, nsop, n_rst;

  initial begin
    rst_n = 1'b0;
    bus.src0_req = 1'b0; bus.src0_data = 8'h00;
    bus.src1_req = 1'b0; bus.src1_data = 8'h00;
    bus.data_out_ack = 1'b0;

    // Reset state.
    do_reset();
    chk("rst_data_out_req", 32'(bus.data_out_req), 32'd0);
    chk("rst_data_out",     32'(bus.data_out),     32'd0);
    chk("rst_data_out_sop", 32'(bus.data_out_sop), 32'd0);

    // One aligned packet 47,00..BA from source 0, continuous ack.
    push_pkt(0, 3, 8'h00); pct0 = 100;
    release_rst();
    run_until("t1_timeout", 188, 400);
    for (int i = 0; i < 188; i++)
      chk("t1_byte", 32'(out_q[i]), (i == 0) ? 32'h47 : 32'(i - 1));
    nsop = 0;
    foreach (sop_q[i]) if (sop_q[i]) nsop++;
    chk("t1_sop_count", 32'(nsop), 32'd1);
    chk("t1_sop_first", 32'(sop_q[0]), 32'd1);

    // Simultaneous candidates: round-robin 0,1,0 with one bubble between.
    do_reset();
    push_pkt(0, 0, 8'h11); push_pkt(0, 0, 8'h11); push_pkt(1, 0, 8'h22);
    pct0 = 100; pct1 = 100;
    release_rst();
    run_until("t2_timeout", 564, 800);
    chk("t2_pkt0_src", 32'(out_q[1]),   32'h11);
    chk("t2_pkt1_src", 32'(out_q[189]), 32'h22);
    chk("t2_pkt2_src", 32'(out_q[377]), 32'h11);
    chk("t2_sop_gap0", 32'(sop_cyc[1] - sop_cyc[0]), 32'd189);
    chk("t2_sop_gap1", 32'(sop_cyc[2] - sop_cyc[1]), 32'd189);

    // Alignment hunt on source 1: 12,34,56 dropped, then the packet.
    do_reset();
    q1.push_back(8'h12); q1.push_back(8'h34); q1.push_back(8'h56);
    push_pkt(1, 0, 8'h5A); pct1 = 100;
    release_rst();
    off = NULL_EN ? 3 * 188 : 0;  // each dropped byte opens a null slot
    run_until("t3_timeout", off + 188, 1200);
    chk("t3_first_byte", 32'(out_q[off]),     32'h47);
    chk("t3_second_byte", 32'(out_q[off + 1]), 32'h5A);
    chk("t3_src1_drained", 32'(q1.size()),    32'd0);

    // Random 50% back-pressure: output sequence equals input.
    do_reset();
    push_pkt(0, 1, 8'h00); ref_q = q0; pct0 = 100; ack_pct = 50;
    release_rst();
    run_until("t4_timeout", 188, 1000);
    for (int i = 0; i < 188; i++) chk("t4_byte", 32'(out_q[i]), 32'(ref_q[i]));
    chk("t4_src0_drained", 32'(q0.size()), 32'd0);

    // Reset at byte 100 of a packet.
    do_reset();
    push_pkt(0, 2, 8'h00); pct0 = 100;
    release_rst();
    run_until("t5_timeout", 100, 400);
    rst_n = 1'b0; ack_pct = 0;
    step();
    rst_n = 1'b1;
    n_rst = out_q.size();
    chk("t5_req_after_rst", 32'(bus.data_out_req), 32'd0);
    for (int k = 0; k < 300; k++) step();
    chk("t5_no_regrant", 32'(out_q.size()), 32'(n_rst));
    chk("t5_tail_dropped", 32'(q0.size()), 32'd0);

`ifdef ZL_TS_NULL_INSERT_EN
    // Null insertion with no source, source 0 arriving mid-null waits.
    do_reset();
    release_rst();
    run_until("t6_timeout_a", 50, 200);
    push_pkt(0, 0, 8'h33); pct0 = 100;
    run_until("t6_timeout_b", 376, 600);
    chk("t6_null_b0", 32'(out_q[0]), 32'h47);
    chk("t6_null_b1", 32'(out_q[1]), 32'h1F);
    chk("t6_null_b2", 32'(out_q[2]), 32'hFF);
    chk("t6_null_b3", 32'(out_q[3]), 32'h10);
    for (int i = 4; i < 188; i++) chk("t6_null_fill", 32'(out_q[i]), 32'hFF);
    nsop = 0;
    for (int i = 0; i < 188; i++) if (sop_q[i]) nsop++;
    chk("t6_null_sop", 32'(nsop), 32'd1);
    chk("t6_src_after_null0", 32'(out_q[188]), 32'h47);
    chk("t6_src_after_null1", 32'(out_q[189]), 32'h33);
`endif

    // Randomized traffic: garbage gaps, random req, random back-pressure.
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int s = 0; s < 2; s++) begin
        for (int g = 0; g < int'($urandom_range(3)); g++) begin
          logic [7:0] gb;
          gb = 8'($urandom_range(255));
          if (gb == 8'h47) gb = 8'h00;
          if (s == 0) q0.push_back(gb); else q1.push_back(gb);
        end
        push_pkt(s, 1, 8'h00);
      end
    end
    pct0 = $urandom_range(60, 100); pct1 = $urandom_range(60, 100); ack_pct = 75;
    release_rst();
    for (int k = 0; k < 4000; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
